// File: rtl/ws2812_pkg.sv
// WS2812 shared types, timing defaults and helpers.
// Used by both the WS2812 transmitter and the receiver.
package ws2812_pkg;

  localparam int unsigned DEF_CLK_FREQ     = 27_000_000;
  localparam int unsigned DEF_T0H_NS       = 400;
  localparam int unsigned DEF_T1H_NS       = 800;
  localparam int unsigned DEF_BIT_NS       = 1250;
  localparam int unsigned DEF_T1_THRESH_NS = 600;
  localparam int unsigned DEF_GLITCH_NS    = 150;
  localparam int unsigned DEF_HIGH_MAX_NS  = 2000;
  localparam int unsigned DEF_RESET_NS     = 50000;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    UNSYNC,
    IDLE,
    HIGH,
    LOW
  } rx_state_t;

  function automatic int unsigned ns_to_cycles(
    input longint unsigned freq_hz,
    input longint unsigned ns
  );
    return 32'((freq_hz * ns) / 64'd1_000_000_000);
  endfunction

endpackage

// File: rtl/ws2812_rx_sync.sv
// WS2812 line input: 2-FF synchroniser plus registered edge detector.
// rise/fall are valid in the cycle after the level settles in stage 2.
module ws2812_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic level
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 waveform decoder: recovers GRB pixels and frame latches.
// Optional WS2812_RX_STATS_EN adds error and frame counters.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
  parameter int unsigned T1_THRESH_NS = DEF_T1_THRESH_NS,
  parameter int unsigned GLITCH_NS    = DEF_GLITCH_NS,
  parameter int unsigned HIGH_MAX_NS  = DEF_HIGH_MAX_NS,
  parameter int unsigned RESET_NS     = DEF_RESET_NS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] pixel,
  output logic        pixel_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic [8:0]  frame_len,
  output logic        bit_error,
  output logic [15:0] err_count,
  output logic [15:0] frame_count
);

  localparam int unsigned T1_CYC =
    ns_to_cycles(64'(CLK_FREQ), 64'(T1_THRESH_NS));
  localparam int unsigned GL_CYC =
    ns_to_cycles(64'(CLK_FREQ), 64'(GLITCH_NS));
  localparam int unsigned HM_CYC =
    ns_to_cycles(64'(CLK_FREQ), 64'(HIGH_MAX_NS));
  localparam int unsigned RS_CYC =
    ns_to_cycles(64'(CLK_FREQ), 64'(RESET_NS));
  localparam int unsigned CW = $clog2(RS_CYC + 1);

  localparam logic [CW-1:0] T1_C    = CW'(T1_CYC);
  localparam logic [CW-1:0] GL_C    = CW'(GL_CYC);
  localparam logic [CW-1:0] HM_C    = CW'(HM_CYC - 1);
  localparam logic [CW-1:0] RS_C    = CW'(RS_CYC);
  localparam logic [CW-1:0] RM_C    = CW'(RS_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic rise;
  logic fall;
  logic level;

  ws2812_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .rise  (rise),
    .fall  (fall),
    .level (level)
  );

  rx_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [4:0]  bit_q, bit_d;
  logic [23:0] sh_q, sh_d;
  logic [8:0]  pix_q, pix_d;
  logic [7:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic        ovf_q, ovf_d;
  logic        err_d;
  logic        done_d;
  logic [8:0]  flen_d;
  logic        din_bit;
  pixel_t      pix_r;

  assign pixel = pix_r;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    pix_d   = pix_q;
    idx_d   = idx_q;
    pend_d  = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    done_d  = 1'b0;
    flen_d  = frame_len;
    din_bit = (cnt_q >= T1_C);
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    unique case (state_q)
      UNSYNC: begin
        if (level) begin
          cnt_d = '0;
        end else if (cnt_q == RS_C) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      IDLE: begin
        if (rise) begin
          cnt_d   = CW'(1);
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          cnt_d   = CW'(1);
          if (cnt_q < GL_C) begin
            err_d = 1'b1;
          end else begin
            sh_d = {sh_q[22:0], din_bit};
            if (bit_q == 5'd23) begin
              // Full word: hand it to the output stage next cycle.
              bit_d  = '0;
              pend_d = 1'b1;
              ovf_d  = pix_q[8];
              idx_d  = pix_q[8] ? 8'hFF : pix_q[7:0];
              if (!pix_q[8]) pix_d = pix_q + 9'd1;
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end else if (cnt_q == HM_C) begin
          err_d   = 1'b1;
          state_d = UNSYNC;
          cnt_d   = '0;
          bit_d   = '0;
          pix_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LOW: begin
        if (rise) begin
          cnt_d   = CW'(1);
          state_d = HIGH;
        end else if (cnt_q == RM_C) begin
          done_d  = 1'b1;
          flen_d  = pix_q;
          err_d   = (bit_q != 5'd0);
          bit_d   = '0;
          pix_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNSYNC;
      cnt_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      pix_q       <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pix_r       <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      frame_len   <= '0;
      bit_error   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      pix_q       <= pix_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      pixel_valid <= pend_q;
      if (pend_q) begin
        pix_r       <= pixel_t'(sh_q);
        pixel_index <= idx_q;
      end
      frame_done  <= done_d;
      frame_len   <= flen_d;
      bit_error   <= err_d | (pend_q & ovf_q);
    end
  end

`ifdef WS2812_RX_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      if (bit_error && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
      if (frame_done)
        frame_count <= frame_count + 16'd1;
    end
  end
`else
  assign err_count   = '0;
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomised and directed bench for ws2812_rx against a pulse-level model.
// Build with WS2812_RX_STATS_EN to check the statistics counters.
module tb_ws2812_rx;

  localparam int T0H    = 11;
  localparam int T1H    = 22;
  localparam int TLO    = 12;
  localparam int GAP    = 1400;
  localparam int T1     = 16;
  localparam int GLITCH = 4;
  localparam int HMAX   = 54;

  logic        clk = 1'b0;
  logic        reset;
  logic        din;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [8:0]  frame_len;
  logic        bit_error;
  logic [15:0] err_count;
  logic [15:0] frame_count;

  ws2812_rx dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .frame_len   (frame_len),
    .bit_error   (bit_error),
    .err_count   (err_count),
    .frame_count (frame_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [23:0] pix;
    logic [7:0]  idx;
    logic        ovf;
  } pix_exp_t;

  typedef struct {
    logic [8:0] len;
    logic       err;
  } frm_exp_t;

  pix_exp_t pq[$];
  frm_exp_t fq[$];
  pix_exp_t pe;
  frm_exp_t fe;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic rst_seen = 1'b1;

  // observations from the compare process
  int obs_err = 0;
  int obs_frames = 0;
  logic [23:0] last_pix = '0;
  logic [7:0]  last_idx = '0;
  logic [8:0]  last_flen = '0;
  logic        last_ferr = 1'b0;
  int last_pix_cyc = 0;

  // pulse-level model state
  bit m_sync;
  bit m_in;
  int m_nb;
  int m_pix;
  logic [23:0] m_sh;
  int exp_err = 0;
  int t_fall = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_sync = 0;
    m_in = 0;
    m_nb = 0;
    m_pix = 0;
    m_sh = '0;
  endtask

  task automatic m_high(input int n);
    if (m_sync) begin
      m_in = 1;
      if (n >= HMAX) begin
        exp_err++;
        m_nb = 0;
        m_pix = 0;
        m_sync = 0;
        m_in = 0;
      end else if (n < GLITCH) begin
        exp_err++;
      end else begin
        m_sh = {m_sh[22:0], (n >= T1) ? 1'b1 : 1'b0};
        m_nb++;
        if (m_nb == 24) begin
          pq.push_back('{m_sh, (m_pix > 255) ? 8'd255 : 8'(m_pix),
                         (m_pix == 256) ? 1'b1 : 1'b0});
          if (m_pix == 256) exp_err++;
          else m_pix++;
          m_nb = 0;
        end
      end
    end
  endtask

  task automatic m_low(input int n);
    if (n >= 1000) begin
      if (!m_sync) begin
        m_sync = 1;
      end else if (m_in) begin
        fq.push_back('{9'(m_pix), (m_nb != 0) ? 1'b1 : 1'b0});
        if (m_nb != 0) exp_err++;
        m_pix = 0;
        m_nb = 0;
        m_in = 0;
      end
    end
  endtask

  task automatic hi(input int n);
    m_high(n);
    din = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lo(input int n);
    m_low(n);
    t_fall = cyc + 1;
    din = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] p, input int nb);
    for (int i = 23; i > 23 - nb; i--) begin
      hi(p[i] ? T1H : T0H);
      lo(TLO);
    end
  endtask

  task automatic send_pix(input logic [23:0] p);
    send_bits(p, 24);
  endtask

  task automatic rnd_bit(input logic b);
    if (b) hi($urandom_range(T1, HMAX - 1));
    else   hi($urandom_range(GLITCH, T1 - 1));
    lo($urandom_range(3, 20));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    din = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_seen <= reset;
  end

  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset_quiet", {29'd0, pixel_valid, frame_done, bit_error}, 32'd0);
    end else begin
      chk("pv_fd_excl", {31'd0, pixel_valid & frame_done}, 32'd0);
      if (bit_error) obs_err++;
      if (pixel_valid) begin
        last_pix = pixel;
        last_idx = pixel_index;
        last_pix_cyc = cyc;
        chk("pix_expected", {31'd0, pq.size() != 0}, 32'd1);
        if (pq.size() != 0) begin
          pe = pq.pop_front();
          chk("pixel", 32'(pixel), 32'(pe.pix));
          chk("pixel_index", 32'(pixel_index), 32'(pe.idx));
          chk("pix_err", 32'(bit_error), 32'(pe.ovf));
        end
      end
      if (frame_done) begin
        obs_frames++;
        last_flen = frame_len;
        last_ferr = bit_error;
        chk("frm_expected", {31'd0, fq.size() != 0}, 32'd1);
        if (fq.size() != 0) begin
          fe = fq.pop_front();
          chk("frame_len", 32'(frame_len), 32'(fe.len));
          chk("frm_err", 32'(bit_error), 32'(fe.err));
        end
      end
    end
  end

  int e0;
  int f0;
  int tf;

  initial begin
    reset = 1'b1;
    din = 1'b0;
    m_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_pv", 32'(pixel_valid), 32'd0);
    chk("rst_idx", 32'(pixel_index), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_flen", 32'(frame_len), 32'd0);
    chk("rst_berr", 32'(bit_error), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_frmcnt", 32'(frame_count), 32'd0);
    reset = 1'b0;

    // single pixel and latency
    lo(GAP);
    e0 = obs_err;
    send_pix(24'hA5C3F0);
    tf = t_fall;
    lo(GAP);
    chk("t1_pix", 32'(last_pix), 32'hA5C3F0);
    chk("t1_idx", 32'(last_idx), 32'd0);
    chk("t1_latency", 32'(last_pix_cyc - tf), 32'd3);
    chk("t1_flen", 32'(last_flen), 32'd1);
    chk("t1_noerr", 32'(obs_err - e0), 32'd0);

    // three pixels, then a fresh frame
    send_pix(24'h000000);
    send_pix(24'hFFFFFF);
    send_pix(24'h123456);
    lo(GAP);
    chk("t2_idx", 32'(last_idx), 32'd2);
    chk("t2_flen", 32'(last_flen), 32'd3);
    send_pix(24'h654321);
    lo(GAP);
    chk("t2_idx0", 32'(last_idx), 32'd0);

    // boundary widths 15,16,3,4
    e0 = obs_err;
    hi(15); lo(TLO);
    hi(16); lo(TLO);
    hi(3);  lo(TLO);
    hi(4);  lo(TLO);
    send_bits(24'hFFFFFF, 21);
    lo(GAP);
    chk("t3_pix", 32'(last_pix), 32'h5FFFFF);
    chk("t3_err", 32'(obs_err - e0), 32'd1);

    // partial pixel at latch
    e0 = obs_err;
    send_bits(24'hABCDEF, 10);
    lo(GAP);
    chk("t4_flen", 32'(last_flen), 32'd0);
    chk("t4_ferr", 32'(last_ferr), 32'd1);
    send_pix(24'h0F0F0F);
    lo(GAP);
    chk("t4_pix", 32'(last_pix), 32'h0F0F0F);
    chk("t4_err", 32'(obs_err - e0), 32'd1);

    // stuck-high line
    e0 = obs_err;
    f0 = obs_frames;
    send_bits(24'hFFFFFF, 5);
    hi(60);
    lo(GAP);
    chk("t5_err", 32'(obs_err - e0), 32'd1);
    chk("t5_nofrm", 32'(obs_frames - f0), 32'd0);
    send_pix(24'h3C3C3C);
    lo(GAP);
    chk("t5_pix", 32'(last_pix), 32'h3C3C3C);
    chk("t5_idx", 32'(last_idx), 32'd0);

    // reset mid pixel
    send_bits(24'hFFF000, 12);
    pulse_reset();
    lo(GAP);
    send_pix(24'hC0FFEE);
    lo(GAP);
    chk("t6_pix", 32'(last_pix), 32'hC0FFEE);
    chk("t6_idx", 32'(last_idx), 32'd0);

    // statistics: three errors over two frames
    pulse_reset();
    e0 = obs_err;
    f0 = obs_frames;
    lo(GAP);
    hi(2); lo(TLO);
    send_pix(24'h00FF00);
    lo(GAP);
    hi(2); lo(TLO);
    send_bits(24'h5A5A5A, 10);
    lo(GAP);
    chk("t7_err", 32'(obs_err - e0), 32'd3);
    chk("t7_frm", 32'(obs_frames - f0), 32'd2);
`ifdef WS2812_RX_STATS_EN
    chk("t7_errcnt", 32'(err_count), 32'd3);
    chk("t7_frmcnt", 32'(frame_count), 32'd2);
`else
    chk("t7_errcnt", 32'(err_count), 32'd0);
    chk("t7_frmcnt", 32'(frame_count), 32'd0);
`endif

    // index saturation: 257 pixels in one frame
    e0 = obs_err;
    for (int p = 0; p < 257; p++) begin
      for (int b = 0; b < 24; b++) begin
        hi(4);
        lo(1);
      end
    end
    lo(GAP);
    chk("t8_idx", 32'(last_idx), 32'd255);
    chk("t8_flen", 32'(last_flen), 32'd256);
    chk("t8_err", 32'(obs_err - e0), 32'd1);

    // randomised frames
    for (int f = 0; f < 4; f++) begin
      int npix;
      npix = $urandom_range(0, 2);
      for (int p = 0; p < npix; p++) begin
        logic [23:0] v;
        v = 24'($urandom);
        if ($urandom_range(0, 5) == 0) begin
          hi($urandom_range(1, GLITCH - 1));
          lo($urandom_range(3, 20));
        end
        for (int i = 23; i >= 0; i--) rnd_bit(v[i]);
      end
      if ($urandom_range(0, 3) == 0) begin
        int nb;
        nb = $urandom_range(1, 23);
        for (int i = 0; i < nb; i++) rnd_bit(1'($urandom));
      end
      lo(GAP);
    end

    lo(50);
    chk("err_total", 32'(obs_err), 32'(exp_err));
    chk("pix_drain", 32'(pq.size()), 32'd0);
    chk("frm_drain", 32'(fq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
